clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 9 +
 rtl/clk_div_chan.sv | 46 ++++
 rtl/clk_div_multi.sv | 43 ++++
 tb/tb_clk_div_multi.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and high-time clamp for the multi-channel clock divider
package clk_div_pkg;
  localparam int CLK_DIV_WIDTH = 28;
  localparam logic [CLK_DIV_WIDTH-1:0] CLK_DIV_DEF_DIV = 28'd170358;
  localparam logic [CLK_DIV_WIDTH-1:0] CLK_DIV_DEF_HIGH = CLK_DIV_DEF_DIV / 2;
  function automatic logic [31:0] clamp_high(input logic [31:0] div, input logic [31:0] high);
    return high == 32'd0 ? 32'd1 : (high >= div ? div - 32'd1 : high);
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed config applied only at period boundaries
module clk_div_chan #(
  parameter int WIDTH = 28,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(10),
  parameter logic [WIDTH-1:0] DEF_HIGH = DEF_DIV / 2
)(
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_div,
  input  logic [WIDTH-1:0] ld_high,
  output logic             clock_out,
  output logic             tick
);
  logic [WIDTH-1:0] cnt, div_a, high_a, div_s, high_s;
  logic pending, wrap, apply;
  assign wrap = enable && cnt == div_a - WIDTH'(1);
  assign apply = pending && (!enable || wrap);
  // counter, shadow/active transfer on wrap (or immediately while stopped), registered outputs
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      div_a <= DEF_DIV;
      high_a <= DEF_HIGH;
      div_s <= DEF_DIV;
      high_s <= DEF_HIGH;
      pending <= 1'b0;
      clock_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt <= (enable && !wrap) ? cnt + WIDTH'(1) : '0;
      if (apply) begin
        div_a <= div_s;
        high_a <= high_s;
      end
      if (load) begin
        div_s <= ld_div;
        high_s <= ld_high;
      end
      pending <= load || (pending && !apply);
      clock_out <= enable && cnt < high_a;
      tick <= enable && cnt == '0;
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent glitch-free clock dividers sharing one config write port
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WIDTH = CLK_DIV_WIDTH,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(CLK_DIV_DEF_DIV),
  parameter logic [WIDTH-1:0] DEF_HIGH = DEF_DIV / 2,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
)(
  input  logic             clock_in,
  input  logic             reset,
  input  logic [NCH-1:0]   enable,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [WIDTH-1:0] wr_high,
  output logic             wr_err,
  output logic [NCH-1:0]   clock_out,
  output logic [NCH-1:0]   tick
);
  logic wr_ok;
  logic [WIDTH-1:0] high_c;
  assign wr_ok = wr_div >= WIDTH'(2) && 32'(wr_ch) < NCH;
  assign high_c = WIDTH'(clamp_high(32'(wr_div), 32'(wr_high)));
  // rejected writes (divisor below 2 or nonexistent channel) flag a one-cycle error
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) wr_err <= 1'b0;
    else wr_err <= wr_en && !wr_ok;
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)) u_chan (
      .clock_in (clock_in),
      .reset    (reset),
      .enable   (enable[i]),
      .load     (wr_en && wr_ok && 32'(wr_ch) == i),
      .ld_div   (wr_div),
      .ld_high  (high_c),
      .clock_out(clock_out[i]),
      .tick     (tick[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed checks of periods, high times, shadowed writes, enable and async reset
module tb_clk_div_multi;
  logic clock_in, reset, wr_en, wr_err;
  logic [3:0] enable, clock_out, tick;
  logic [1:0] wr_ch;
  logic [27:0] wr_div, wr_high;
  int checks = 0, errors = 0;
  int per, hi, n;

  clk_div_multi #(.NCH(4), .WIDTH(28), .DEF_DIV(28'd10), .DEF_HIGH(28'd5)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .wr_high  (wr_high),
    .wr_err   (wr_err),
    .clock_out(clock_out),
    .tick     (tick)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int ch);
    int k = 0;
    while (!tick[ch] && k < 64) begin
      @(negedge clock_in);
      k++;
    end
    if (!tick[ch]) check($sformatf("tick%0d_timeout", ch), int'(tick[ch]), 1);
  endtask

  task automatic measure(input int ch, output int p, output int h);
    wait_tick(ch);
    p = 0;
    h = 0;
    do begin
      h += int'(clock_out[ch]);
      p++;
      @(negedge clock_in);
    end while (!tick[ch] && p < 64);
  endtask

  task automatic wr(input int ch, input int d, input int h);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_div = 28'(d);
    wr_high = 28'(h);
    @(negedge clock_in);
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 4'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_clock_out", int'(clock_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_wr_err", int'(wr_err), 0);
    repeat (2) @(negedge clock_in);
    reset = 1'b0;
    @(negedge clock_in);
    enable = 4'b1111;
    measure(0, per, hi);
    check("ch0_def_period", per, 10);
    check("ch0_def_high", hi, 5);
    measure(3, per, hi);
    check("ch3_def_period", per, 10);
    check("ch3_def_high", hi, 5);
    // mid-period write to ch1: current period keeps its old length
    wait_tick(1);
    n = 0;
    repeat (3) begin @(negedge clock_in); n++; end
    wr(1, 7, 3);
    n++;
    check("ch1_write_no_err", int'(wr_err), 0);
    while (!tick[1] && n < 64) begin @(negedge clock_in); n++; end
    check("ch1_old_period", n, 10);
    measure(1, per, hi);
    check("ch1_new_period", per, 7);
    check("ch1_new_high", hi, 3);
    measure(1, per, hi);
    check("ch1_new_period2", per, 7);
    // rejected write
    wait_tick(1);
    @(negedge clock_in);
    wr(1, 1, 0);
    check("err_pulse", int'(wr_err), 1);
    @(negedge clock_in);
    check("err_one_cycle", int'(wr_err), 0);
    measure(1, per, hi);
    check("ch1_after_err_period", per, 7);
    check("ch1_after_err_high", hi, 3);
    // clamps: high>=div -> div-1, high 0 -> 1
    wait_tick(1);
    @(negedge clock_in);
    wr(1, 4, 9);
    check("clamp_no_err", int'(wr_err), 0);
    measure(1, per, hi);
    check("clamp_hi_period", per, 4);
    check("clamp_hi_high", hi, 3);
    wait_tick(1);
    @(negedge clock_in);
    wr(1, 5, 0);
    measure(1, per, hi);
    check("clamp_lo_period", per, 5);
    check("clamp_lo_high", hi, 1);
    // double write before wrap: last one wins, other channels untouched
    wait_tick(2);
    @(negedge clock_in);
    wr(2, 6, 2);
    wr(2, 8, 4);
    measure(2, per, hi);
    check("ch2_last_write_period", per, 8);
    check("ch2_last_write_high", hi, 4);
    measure(0, per, hi);
    check("ch0_untouched", per, 10);
    measure(3, per, hi);
    check("ch3_untouched", per, 10);
    // disable ch3 mid-period, write while stopped, re-enable
    wait_tick(3);
    repeat (2) @(negedge clock_in);
    enable[3] = 1'b0;
    @(negedge clock_in);
    check("dis_clock_out", int'(clock_out[3]), 0);
    check("dis_tick", int'(tick[3]), 0);
    wr(3, 3, 1);
    repeat (2) @(negedge clock_in);
    check("dis_hold_clock_out", int'(clock_out[3]), 0);
    enable[3] = 1'b1;
    @(negedge clock_in);
    check("reen_tick", int'(tick[3]), 1);
    check("reen_clock_out", int'(clock_out[3]), 1);
    measure(3, per, hi);
    check("reen_period", per, 3);
    check("reen_high", hi, 1);
    // async reset pulse between clock edges
    wait_tick(0);
    wr(0, 0, 0);
    check("pre_rst_wr_err", int'(wr_err), 1);
    check("pre_rst_clock_out0", int'(clock_out[0]), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_clock_out", int'(clock_out), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_wr_err", int'(wr_err), 0);
    reset = 1'b0;
    @(negedge clock_in);
    check("rst_restart_tick", int'(tick), 15);
    measure(1, per, hi);
    check("rst_ch1_period", per, 10);
    check("rst_ch1_high", hi, 5);
    measure(3, per, hi);
    check("rst_ch3_period", per, 10);
    check("rst_ch3_high", hi, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
